// File: rtl/sc_backg_scroll_datapath.sv
// Background scroll datapath.
// Acts on the background state machine's active-low strobes: clear
// reinitialises everything, load scrolls the bitmap down one row and
// restarts the timer, upcount advances the timer toward its limit.
// The timer period is latched from speed at clear/load time only.
module sc_backg_scroll_datapath #(
   parameter int                        ROWS         = 8,
   parameter int                        COLS         = 8,
   parameter int                        COUNT_WIDTH  = 23,
   parameter int                        TIMER_LIMIT  = 5000000,
   parameter logic [ROWS*COLS-1:0]      INIT_PATTERN = 64'h81818181818181FF
) (
   input  logic                         SC_BACKGSCROLL_CLOCK_50,
   input  logic                         SC_BACKGSCROLL_RESET_InHigh,
   input  logic                         SC_BACKGSCROLL_clear_InLow,
   input  logic                         SC_BACKGSCROLL_load_InLow,
   input  logic                         SC_BACKGSCROLL_upcount_InLow,
   input  logic [1:0]                   SC_BACKGSCROLL_speed_In,
   output logic                         SC_BACKGSCROLL_T0_OutLow,
   output logic [ROWS*COLS-1:0]         SC_BACKGSCROLL_data_Out,
   output logic [7:0]                   SC_BACKGSCROLL_scroll_Out
);

   localparam int                       DataWidth  = ROWS * COLS;
   localparam logic [COUNT_WIDTH-1:0]   TimerLimit = COUNT_WIDTH'(TIMER_LIMIT);

   logic [COUNT_WIDTH-1:0] count_reg;
   logic [COUNT_WIDTH-1:0] limit_reg;
   logic [DataWidth-1:0]   rows_reg;
   logic [7:0]             scroll_reg;

   logic [COUNT_WIDTH-1:0] limitSel;
   logic [DataWidth-1:0]   rowsRotated;
   logic                   timerExpired;

   // Period for the next timer run: base limit divided by 2^speed (truncating).
   always_comb begin
      limitSel = TimerLimit >> SC_BACKGSCROLL_speed_In;
   end

   // Rotate down one row: row i takes row i-1, top row (row 0) takes the last row.
   always_comb begin
      rowsRotated = {rows_reg[DataWidth-COLS-1:0], rows_reg[DataWidth-1 -: COLS]};
   end

   // Expiry is a pure compare so T0 falls in the cycle the count reaches the limit.
   always_comb begin
      timerExpired = (count_reg >= limit_reg);
   end

   // Register update, priority reset > clear > load > upcount > hold.
   always_ff @(posedge SC_BACKGSCROLL_CLOCK_50) begin
      if (SC_BACKGSCROLL_RESET_InHigh) begin
         count_reg  <= '0;
         limit_reg  <= TimerLimit;
         rows_reg   <= INIT_PATTERN;
         scroll_reg <= '0;
      end else if (!SC_BACKGSCROLL_clear_InLow) begin
         count_reg  <= '0;
         limit_reg  <= limitSel;
         rows_reg   <= INIT_PATTERN;
         scroll_reg <= '0;
      end else if (!SC_BACKGSCROLL_load_InLow) begin
         count_reg  <= '0;
         limit_reg  <= limitSel;
         rows_reg   <= rowsRotated;
         scroll_reg <= scroll_reg + 8'd1;
      end else if (!SC_BACKGSCROLL_upcount_InLow) begin
         // Saturate at the limit; the count never wraps.
         if (!timerExpired) begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

   assign SC_BACKGSCROLL_T0_OutLow  = ~timerExpired;
   assign SC_BACKGSCROLL_data_Out   = rows_reg;
   assign SC_BACKGSCROLL_scroll_Out = scroll_reg;

endmodule

// File: tb/tb_sc_backg_scroll_datapath.sv
// Bench for the background scroll datapath, built with an 8-tick base period.
module tb_sc_backg_scroll_datapath;

   localparam int ExpW = 64 + 8 + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   logic clr_n, ld_n, up_n;
   logic [1:0] speed;
   logic t0_n;
   logic [63:0] data;
   logic [7:0] scroll;

   always #5 clk = ~clk;

   sc_backg_scroll_datapath #(
      .ROWS        (8),
      .COLS        (8),
      .COUNT_WIDTH (23),
      .TIMER_LIMIT (8),
      .INIT_PATTERN(64'h81818181818181FF)
   ) dut (
      .SC_BACKGSCROLL_CLOCK_50      (clk),
      .SC_BACKGSCROLL_RESET_InHigh  (rst),
      .SC_BACKGSCROLL_clear_InLow   (clr_n),
      .SC_BACKGSCROLL_load_InLow    (ld_n),
      .SC_BACKGSCROLL_upcount_InLow (up_n),
      .SC_BACKGSCROLL_speed_In      (speed),
      .SC_BACKGSCROLL_T0_OutLow     (t0_n),
      .SC_BACKGSCROLL_data_Out      (data),
      .SC_BACKGSCROLL_scroll_Out    (scroll)
   );

   // ---------------- scoreboard state ----------------
   logic [ExpW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: bitmap kept as an array of rows, row 0 at the top.
   logic [7:0]  m_rows [8];
   int unsigned m_count;
   int unsigned m_limit;
   logic [7:0]  m_scroll;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic model_init();
      for (int i = 0; i < 8; i++) m_rows[i] = (i == 0) ? 8'hFF : 8'h81;
      m_count  = 0;
      m_limit  = 8;
      m_scroll = 8'd0;
   endtask

   function automatic logic [63:0] model_data();
      logic [63:0] d;
      for (int i = 0; i < 8; i++) d[i*8 +: 8] = m_rows[i];
      return d;
   endfunction

   task automatic model_step(input logic r, input logic c, input logic l, input logic u,
                             input logic [1:0] s);
      logic [7:0] tmp [8];
      if (r) begin
         model_init();
      end else if (!c) begin
         model_init();
         m_limit = 8 >> s;
      end else if (!l) begin
         for (int i = 1; i < 8; i++) tmp[i] = m_rows[i-1];
         tmp[0] = m_rows[7];
         for (int i = 0; i < 8; i++) m_rows[i] = tmp[i];
         m_scroll = m_scroll + 8'd1;
         m_count  = 0;
         m_limit  = 8 >> s;
      end else if (!u) begin
         if (m_count < m_limit) m_count++;
      end
   endtask

   // ---------------- driver ----------------
   // Drives one cycle of strobes, pushes the model's prediction, and compares
   // the DUT outputs just after the edge.
   task automatic step(input logic r, input logic c, input logic l, input logic u,
                       input logic [1:0] s, input string tag);
      logic [ExpW-1:0] e;
      @(negedge clk);
      rst = r; clr_n = c; ld_n = l; up_n = u; speed = s;
      model_step(r, c, l, u, s);
      exp_q.push_back({model_data(), m_scroll, (m_count >= m_limit) ? 1'b0 : 1'b1});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_val({tag, "_queue"}, 64'd0, 64'd1);
      end else begin
         e = exp_q.pop_front();
         check_val({tag, "_data"},   data,          e[72:9]);
         check_val({tag, "_scroll"}, 64'(scroll),   64'(e[8:1]));
         check_val({tag, "_t0"},     64'(t0_n),     64'(e[0]));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; clr_n = 1'b1; ld_n = 1'b1; up_n = 1'b1; speed = 2'd0;
      model_init();

      // Reset then idle.
      step(1, 1, 1, 1, 0, "reset");
      for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 0, "idle");
      check_val("idle_init_pattern", data, 64'h81818181818181FF);

      // Ten upcounts at speed 0: expiry on the 8th, saturation afterwards.
      for (int i = 1; i <= 10; i++) begin
         step(0, 1, 1, 0, 0, "upcount");
         if (i == 7) check_val("t0_before_limit", 64'(t0_n), 64'd1);
         if (i == 8) check_val("t0_at_limit", 64'(t0_n), 64'd0);
      end

      // One scroll, then seven more to wrap the bitmap.
      step(0, 1, 0, 1, 0, "load1");
      check_val("load1_bitmap", data, 64'h818181818181FF81);
      for (int i = 0; i < 7; i++) step(0, 1, 0, 1, 0, "load_more");
      check_val("load8_wrap", data, 64'h81818181818181FF);
      check_val("load8_scroll", 64'(scroll), 64'd8);

      // Fastest speed: a single increment expires; a speed change mid-run is ignored.
      step(0, 1, 0, 0, 3, "load_fast");
      step(0, 1, 1, 0, 3, "up_fast");
      check_val("fast_expired", 64'(t0_n), 64'd0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, "speed_mid");
      step(0, 1, 0, 1, 0, "load_slow");
      for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0, "up_slow");

      // Clear and load together after three scrolls: clear wins.
      for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, "scroll3");
      step(0, 0, 0, 1, 0, "clear_load");
      check_val("clear_load_scroll", 64'(scroll), 64'd0);
      for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0, "after_clear");

      // Reset mid-count at 5 while upcount is held.
      step(0, 0, 1, 1, 0, "clear");
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, "up_to5");
      step(1, 1, 1, 0, 0, "reset_mid");
      for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0, "up_after_rst");

      // Random strobe mix.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 15) != 0),
              ($urandom_range(0, 5) != 0), ($urandom_range(0, 3) == 0),
              2'($urandom_range(0, 3)), "random");
      end

      check_val("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
